// File: rtl/nano_mem_responder.sv
// Memory-side responder for the NanoCPU bus: program loader, combinational
// read port, synchronous write port and one memory-mapped output register.
module nano_mem_responder #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] OUT_ADDR = 8'hFF
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataW,
  input  logic              ce,
  input  logic              we,
  output logic [DATA_W-1:0] dataR,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [15:0]       wr_count
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    LOAD,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ld_ready_q, ld_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic ld_accept;
  logic cpu_wr;
  logic out_hit;

  assign ld_accept = ld_valid && (state_q == LOAD);
  assign cpu_wr    = (state_q == RUN) && ce && we;
  assign out_hit   = cpu_wr && (address == OUT_ADDR);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    wr_count_d  = wr_count_q;
    out_valid_d = out_hit;
    if (ld_accept) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (ld_last || (ptr_q == LAST_PTR)) begin
        state_d = RUN;
      end
    end
    if (cpu_wr && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
    if (out_hit) begin
      out_data_d = dataW;
    end
    // Handshake and CPU reset are registered so they fall right after the final accept edge.
    ld_ready_d = (state_d == LOAD);
    cpu_rst_d  = (state_d == LOAD);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      ld_ready_q  <= 1'b1;
      cpu_rst_q   <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ld_ready_q  <= ld_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Storage is deliberately not reset, so loaded words survive a reset pulse.
  always_ff @(posedge ck) begin
    if (rst_n && ld_accept) begin
      mem_q[ptr_q] <= ld_data;
    end else if (rst_n && cpu_wr) begin
      mem_q[address] <= dataW;
    end
  end

  assign dataR     = ((state_q == RUN) && ce) ? mem_q[address] : '0;
  assign ld_ready  = ld_ready_q;
  assign cpu_rst   = cpu_rst_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_nano_mem_responder.sv
// Randomized self-checking bench for nano_mem_responder against a
// behavioural memory/loader model, plus literal expectations.
module tb_nano_mem_responder;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  address;
  logic [15:0] dataW;
  logic        ce;
  logic        we;
  logic [15:0] dataR;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic [15:0] out_data;
  logic        out_valid;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] wbuf [256];

  nano_mem_responder #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .OUT_ADDR(8'hFF)
  ) dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .address  (address),
    .dataW    (dataW),
    .ce       (ce),
    .we       (we),
    .dataR    (dataR),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .out_data (out_data),
    .out_valid(out_valid),
    .wr_count (wr_count)
  );

  always #5 ck = ~ck;

  // Behavioural model: a loading flag, a load pointer, a word array and the output registers.
  bit          mRun;
  int          mPtr;
  logic [15:0] mMem [256];
  bit          mKnown [256];
  logic [15:0] mOutData;
  bit          mOutValid;
  int          mWrCount;

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      mRun      = 1'b0;
      mPtr      = 0;
      mOutData  = 16'h0;
      mOutValid = 1'b0;
      mWrCount  = 0;
    end else begin
      mOutValid = 1'b0;
      if (!mRun) begin
        if (ld_valid === 1'b1) begin
          mMem[mPtr]   = ld_data;
          mKnown[mPtr] = 1'b1;
          if (ld_last === 1'b1 || mPtr == 255) mRun = 1'b1;
          mPtr = (mPtr + 1) % 256;
        end
      end else if (ce === 1'b1 && we === 1'b1) begin
        mMem[address]   = dataW;
        mKnown[address] = 1'b1;
        mWrCount        = (mWrCount < 65535) ? mWrCount + 1 : 65535;
        if (address == 8'hFF) begin
          mOutData  = dataW;
          mOutValid = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    checkOutput("ld_ready", {31'd0, ld_ready}, {31'd0, !mRun});
    checkOutput("cpu_rst", {31'd0, cpu_rst}, {31'd0, !mRun});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mOutValid});
    checkOutput("out_data", {16'd0, out_data}, {16'd0, mOutData});
    checkOutput("wr_count", {16'd0, wr_count}, mWrCount);
    if (!(mRun && ce === 1'b1))
      checkOutput("dataR_zero", {16'd0, dataR}, 32'd0);
    else if (mKnown[address])
      checkOutput("dataR", {16'd0, dataR}, {16'd0, mMem[address]});
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [7:0] a, input logic [15:0] d);
    ce      = c;
    we      = w;
    address = a;
    dataW   = d;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic loadWords(input int n, input bit useLast, input bit gaps);
    int idx = 0;
    while (idx < n) begin
      ld_data = 16'($urandom);
      ld_last = 1'($urandom);
      if (gaps && ($urandom % 3 == 0)) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_data  = wbuf[idx];
        ld_last  = useLast && (idx == n - 1);
        idx++;
      end
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [7:0] a, input logic [15:0] exp);
    applyStimulus(1'b1, 1'b0, a, 16'h0);
    #1;
    checkOutput(name, {16'd0, dataR}, {16'd0, exp});
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 8'h0, 16'h0);
    ld_valid = 1'b0;
    ld_data  = 16'h0;
    ld_last  = 1'b0;
    tick();
    tick();
    checkOutput("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
    checkOutput("rst_wr_count", {16'd0, wr_count}, 32'd0);
    checkOutput("rst_dataR", {16'd0, dataR}, 32'd0);
    rst_n = 1'b1;
    tick();

    wbuf[0] = 16'h0010;
    wbuf[1] = 16'h1F01;
    wbuf[2] = 16'hF000;
    applyStimulus(1'b1, 1'b1, 8'h01, 16'hDEAD);
    loadWords(3, 1'b1, 1'b0);
    checkOutput("load3_ld_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("load3_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    readCheck("load3_w0", 8'h00, 16'h0010);
    readCheck("load3_w1", 8'h01, 16'h1F01);
    readCheck("load3_w2", 8'h02, 16'hF000);

    doReset();
    loadWords(3, 1'b1, 1'b1);
    readCheck("gap_w0", 8'h00, 16'h0010);
    readCheck("gap_w1", 8'h01, 16'h1F01);
    readCheck("gap_w2", 8'h02, 16'hF000);

    doReset();
    wbuf[0] = 16'hAAAA;
    wbuf[1] = 16'hBBBB;
    loadWords(2, 1'b0, 1'b0);
    doReset();
    wbuf[0] = 16'hCCCC;
    loadWords(1, 1'b1, 1'b0);
    readCheck("midload_w0", 8'h00, 16'hCCCC);
    readCheck("midload_w1", 8'h01, 16'hBBBB);

    doReset();
    for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
    loadWords(256, 1'b0, 1'b1);
    checkOutput("full_ld_ready", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b1;
    ld_data  = ~wbuf[0];
    ld_last  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    readCheck("full_w0", 8'h00, wbuf[0]);
    readCheck("full_w255", 8'hFF, wbuf[255]);

    applyStimulus(1'b1, 1'b1, 8'h05, 16'hABCD);
    tick();
    readCheck("rd5_abcd", 8'h05, 16'hABCD);
    applyStimulus(1'b1, 1'b1, 8'h05, 16'h1234);
    #1;
    checkOutput("wr5_old", {16'd0, dataR}, 32'h0000ABCD);
    tick();
    readCheck("rd5_new", 8'h05, 16'h1234);
    checkOutput("wr_count2", {16'd0, wr_count}, 32'd2);

    applyStimulus(1'b1, 1'b1, 8'hFF, 16'h0042);
    tick();
    checkOutput("outp_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("outp_data", {16'd0, out_data}, 32'h0042);
    readCheck("outp_readback", 8'hFF, 16'h0042);
    checkOutput("outp_valid_fall", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom % 4 != 0), 1'($urandom),
                    ($urandom % 4 == 0) ? 8'hFF : 8'($urandom), 16'($urandom));
      ld_valid = 1'($urandom);
      ld_data  = 16'($urandom);
      ld_last  = 1'($urandom);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;

    applyStimulus(1'b1, 1'b1, 8'hFF, 16'h1357);
    tick();
    checkOutput("prerst_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("runrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    checkOutput("runrst_ld_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("runrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("runrst_wr_count", {16'd0, wr_count}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    wbuf[0] = 16'h7777;
    loadWords(1, 1'b1, 1'b0);
    readCheck("reload_w0", 8'h00, 16'h7777);

    applyStimulus(1'b1, 1'b1, 8'h10, 16'h5A5A);
    repeat (65540) tick();
    checkOutput("wr_count_sat", {16'd0, wr_count}, 32'h0000FFFF);
    applyStimulus(1'b0, 1'b0, 8'h0, 16'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nano_mem_responder.md
# nano_mem_responder

Memory-side responder for the NanoCPU bus, 256 × 16-bit. It serves the CPU's combinational read port and its synchronous write port. Before the CPU runs, it loads a program image through a valid/ready stream and holds the CPU in reset while it does so. It also decodes one memory-mapped output address so a testbench or board can observe CPU results.

## Interface
Parameters:
- ADDR_W, 8: address width; memory depth is 2**ADDR_W words.
- DATA_W, 16: word width.
- OUT_ADDR, 8'hFF: address of the memory-mapped output port.

Ports:
- ck  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- address  in  ADDR_W  CPU word address.
- dataW  in  DATA_W  CPU write data.
- ce  in  1  CPU chip enable.
- we  in  1  CPU write enable; only meaningful with ce=1.
- dataR  out  DATA_W  read data to the CPU, combinational from address.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  marks the final loader word; sampled with ld_valid.
- ld_ready  out  1  responder accepts loader words.
- cpu_rst  out  1  active-high reset to the CPU rst input.
- out_data  out  DATA_W  last value the CPU wrote to OUT_ADDR.
- out_valid  out  1  one-cycle pulse per CPU write to OUT_ADDR.
- wr_count  out  16  number of CPU writes accepted in RUN; saturates at 16'hFFFF.

## Operation
- FSM states: LOAD, RUN.
  - Reset enters LOAD.
  - LOAD → RUN on the accepted beat with ld_last=1, or on the accepted beat at ptr=ADDR_W'(2**ADDR_W-1).
  - RUN persists until reset.
- LOAD:
  - ld_ready=1 and cpu_rst=1.
  - A beat is accepted when ld_valid && ld_ready. It writes mem[ptr] <= ld_data, then ptr <= ptr+1.
  - ptr is ADDR_W bits and reset to 0.
  - CPU-side ce/we are ignored, and dataR=0.
- RUN:
  - ld_ready=0 and cpu_rst=0. ld_valid and ld_data are ignored.
  - dataR = ce ? mem[address] : 0.
  - On ce && we, mem[address] <= dataW at the edge and wr_count increments, saturating.
  - If additionally address==OUT_ADDR, then out_data <= dataW and out_valid=1 for exactly the following cycle. The memory word is still written, so CPU reads of OUT_ADDR return it.
- Memory contents are not reset. Words never loaded are undefined (X in simulation).
- Reset values:
  - State LOAD, ptr=0, ld_ready=1, cpu_rst=1.
  - out_data=0, out_valid=0, wr_count=0.
  - dataR=0.

## Timing
- Loader handshake:
  - A word is accepted on each edge where ld_valid && ld_ready.
  - ld_valid may stay high for back-to-back beats, one word per cycle.
  - The source holds ld_data and ld_last stable while ld_valid=1 and ld_ready=0.
- The final accepted beat at edge N moves the state to RUN at N. cpu_rst and ld_ready are both registered and fall immediately after edge N.
- CPU sequencing after release:
  - The CPU leaves reset at edge N.
  - It spends its IDLE cycle in N..N+1.
  - FETCH of address 0 occurs in cycle N+1..N+2.
- Read latency is zero (combinational): dataR is valid in the same cycle as address. The CPU samples it at the closing edge of FETCH or LD.
- Write latency is one edge. A read of the same address in the same cycle returns the old value; the new value is visible from the next cycle.
- out_valid rises after the write edge and falls after the next edge. Back-to-back OUT_ADDR writes keep out_valid high, with out_data updating each cycle.
- Reset mid-LOAD: ptr returns to 0 and ld_ready stays 1. Already-written words are retained.
- Reset mid-RUN: returns to LOAD, cpu_rst rises asynchronously, out_valid clears, wr_count clears.
- A ce=0 write, or any CPU write during LOAD, has no effect on memory, counters or outputs.

## Test plan
- **Reset state:** assert rst_n=0 → ld_ready=1, cpu_rst=1, out_valid=0, out_data=0, wr_count=0, dataR=0.
- **Program load:**
  - Stimulus: stream 3 words 16'h0010, 16'h1F01, 16'hF000 with ld_last on the 3rd.
  - Response: mem[0..2] hold those values, and ld_ready/cpu_rst fall right after the 3rd accept edge.
  - Repeat with ld_valid gaps and confirm identical contents.
- **Implicit end:** stream 256 words without ld_last → RUN entered on the word at ptr=255, and a 257th word is not accepted.
- **CPU read/write:**
  - Stimulus: in RUN, address=8'h05, ce=1, we=0 with mem[5]=16'hABCD.
  - Response: dataR=16'hABCD in the same cycle.
  - Then write 16'h1234 to 8'h05 → dataR=16'hABCD during the write cycle and 16'h1234 the next cycle; wr_count=1.
- **Output port:** CPU writes 16'h0042 to 8'hFF → out_data=16'h0042 and out_valid high for one cycle; a subsequent read of 8'hFF returns 16'h0042.
- **Full system:**
  - Setup: load a NanoCPU program that computes 5+7 and writes the result to 8'hFF, then executes END.
  - Response: out_valid pulses once with out_data=16'h000C.
  - Then pulse rst_n low mid-RUN → cpu_rst=1 and LOAD re-entered.
